// File: rtl/sar_cmp_responder.sv
// Comparator / sample-and-hold responder for an 8-bit SAR conversion loop.
// Define SAR_CMP_NOISE_EN to add LFSR comparator dither near the held sample.
module sar_cmp_responder #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1   // comparator pipeline depth, legal range 1..3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] smp_data,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic [WIDTH-1:0] trial_code,
    input  logic             conv_done,
    output logic             cmp_out,
    output logic             busy,
    output logic             result_valid,
    output logic             result_ok,
    output logic [WIDTH-1:0] result_code,
    output logic [3:0]       cmp_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   held;
    logic [LATENCY-1:0] pipe;
    logic               take;
    logic               finish;
    logic               ge;
    logic               raw;
    logic               match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        smp_ready    = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        take         = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                smp_ready = 1'b1;
                if (smp_valid) begin
                    take      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (conv_done) begin
                    finish    = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ge = (held >= trial_code);

`ifdef SAR_CMP_NOISE_EN
    logic [7:0]       lfsr;
    logic [WIDTH-1:0] diff;
    logic             near;

    assign diff  = ge ? (held - trial_code) : (trial_code - held);
    assign near  = (diff <= WIDTH'(1));
    assign raw   = ge ^ (near & lfsr[0]);
    assign match = near;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             lfsr <= 8'hE1;
        else if (state == HOLD) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
    end
`else
    assign raw   = ge;
    assign match = (trial_code == held);
`endif

    // The decision pipeline only runs while converting; any exit from HOLD
    // (including the conv_done edge) flushes it so cmp_out idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held        <= '0;
            pipe        <= '0;
            result_code <= '0;
            result_ok   <= 1'b0;
            cmp_count   <= '0;
        end else begin
            if (take) begin
                held      <= smp_data;
                cmp_count <= '0;
            end
            if (state == HOLD && !conv_done) begin
                pipe[0] <= raw;
                for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                if (cmp_count != 4'hF) cmp_count <= cmp_count + 4'd1;
            end else begin
                pipe <= '0;
            end
            if (finish) begin
                result_code <= trial_code;
                result_ok   <= match;
            end
        end
    end

    assign cmp_out = pipe[LATENCY-1];

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Self-checking bench for sar_cmp_responder: directed cases plus random conversions
// against a behavioural model (LATENCY=3 with dither when SAR_CMP_NOISE_EN is defined).
module tb_sar_cmp_responder;

`ifdef SAR_CMP_NOISE_EN
    localparam int LAT   = 3;
    localparam bit NOISE = 1'b1;
`else
    localparam int LAT   = 1;
    localparam bit NOISE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] smp_data = '0;
    logic       smp_valid = 1'b0;
    logic       smp_ready;
    logic [7:0] trial_code = '0;
    logic       conv_done = 1'b0;
    logic       cmp_out;
    logic       busy;
    logic       result_valid;
    logic       result_ok;
    logic [7:0] result_code;
    logic [3:0] cmp_count;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] lfsr_m;
    logic [7:0] trials[32];

    sar_cmp_responder #(.WIDTH(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .trial_code(trial_code), .conv_done(conv_done), .cmp_out(cmp_out),
        .busy(busy), .result_valid(result_valid), .result_ok(result_ok),
        .result_code(result_code), .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
    endfunction

    // Reference decision: sample >= trial, dithered by the LFSR when within one LSB.
    function automatic logic decide(input logic [7:0] s, input logic [7:0] t, input logic [7:0] l);
        logic d;
        d = (s >= t);
        if (NOISE && absdiff(int'(s), int'(t)) <= 1) d = d ^ l[0];
        return d;
    endfunction

    function automatic logic expect_ok(input logic [7:0] s, input logic [7:0] f);
        return NOISE ? (absdiff(int'(s), int'(f)) <= 1) : (s == f);
    endfunction

    // One full conversion: transfer, n trial cycles, conv_done, REPORT, back to IDLE.
    task automatic run_conv(input logic [7:0] s, input int n, input logic [7:0] fin,
                            input bit done_at_xfer, input bit poke);
        logic d[32];
        logic exp_cmp;
        logic ok;
        int   cnt;
        smp_data   = s;
        smp_valid  = 1'b1;
        conv_done  = done_at_xfer;
        trial_code = fin;
        step();
        check("xfer_busy", busy, 1);
        check("xfer_ready", smp_ready, 0);
        check("xfer_cmp", cmp_out, 0);
        check("xfer_count", cmp_count, 0);
        smp_valid = poke;
        smp_data  = 8'h33;
        conv_done = 1'b0;
        for (int j = 0; j < n; j++) begin
            trial_code = trials[j];
            d[j]   = decide(s, trials[j], lfsr_m);
            lfsr_m = lfsr_next(lfsr_m);
            step();
            exp_cmp = (j >= LAT - 1) ? d[j-LAT+1] : 1'b0;
            check("cmp_out", cmp_out, exp_cmp);
            check("hold_ready", smp_ready, 0);
            check("hold_busy", busy, 1);
            check("hold_rv", result_valid, 0);
            check("hold_count", cmp_count, (j + 1 > 15) ? 15 : j + 1);
        end
        ok  = expect_ok(s, fin);
        cnt = (n > 15) ? 15 : n;
        trial_code = fin;
        conv_done  = 1'b1;
        lfsr_m     = lfsr_next(lfsr_m);
        step();
        check("rep_rv", result_valid, 1);
        check("rep_code", result_code, fin);
        check("rep_ok", result_ok, ok);
        check("rep_cmp", cmp_out, 0);
        check("rep_busy", busy, 0);
        check("rep_ready", smp_ready, 0);
        check("rep_count", cmp_count, cnt);
        conv_done = 1'b0;
        smp_valid = poke;
        smp_data  = 8'h77;
        step();
        check("idle_rv", result_valid, 0);
        check("idle_ready", smp_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_cmp", cmp_out, 0);
        check("idle_code", result_code, fin);
        check("idle_ok", result_ok, ok);
        check("idle_count", cmp_count, cnt);
        smp_valid = 1'b0;
    endtask

    task automatic idle_done();
        conv_done  = 1'b1;
        trial_code = 8'($urandom);
        step();
        check("idle_done_ready", smp_ready, 1);
        check("idle_done_busy", busy, 0);
        check("idle_done_rv", result_valid, 0);
        conv_done = 1'b0;
    endtask

    task automatic fill(input logic [7:0] t, input int n);
        for (int i = 0; i < n; i++) trials[i] = t;
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] fin;
        int         n;
        int         sel;

        #12;
        check("rst_ready", smp_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cmp", cmp_out, 0);
        check("rst_rv", result_valid, 0);
        check("rst_ok", result_ok, 0);
        check("rst_code", result_code, 0);
        check("rst_count", cmp_count, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        lfsr_m = 8'hE1;
        step();

        // Nominal binary search on 0x5A.
        trials[0] = 8'h80; trials[1] = 8'h40; trials[2] = 8'h60; trials[3] = 8'h50;
        trials[4] = 8'h58; trials[5] = 8'h5C; trials[6] = 8'h5A; trials[7] = 8'h5B;
        run_conv(8'h5A, 8, 8'h5A, 1'b0, 1'b0);

        // Equality and extreme bounds.
        fill(8'h00, 4); run_conv(8'h00, 4, 8'h00, 1'b0, 1'b0);
        fill(8'hFF, 4); run_conv(8'hFF, 4, 8'hFF, 1'b0, 1'b0);
        fill(8'h00, 4); run_conv(8'hFF, 4, 8'hFF, 1'b0, 1'b0);
        fill(8'h01, 4); run_conv(8'h00, 4, 8'h00, 1'b0, 1'b0);

        // Mismatch, handshake exclusion, conv_done in IDLE and at transfer.
        fill(8'h10, 3); run_conv(8'h10, 3, 8'h11, 1'b0, 1'b0);
        fill(8'h34, 5); run_conv(8'h34, 5, 8'h34, 1'b1, 1'b1);
        idle_done();
        idle_done();

        // Tolerance window of the noisy build.
        fill(8'h40, 4); run_conv(8'h40, 4, 8'h41, 1'b0, 1'b0);
        fill(8'h40, 4); run_conv(8'h40, 4, 8'h42, 1'b0, 1'b0);

        // Reset in the middle of HOLD aborts the conversion.
        smp_data  = 8'h5A;
        smp_valid = 1'b1;
        step();
        smp_valid  = 1'b0;
        trial_code = 8'h10;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", smp_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmp", cmp_out, 0);
        check("mid_rst_rv", result_valid, 0);
        check("mid_rst_count", cmp_count, 0);
        check("mid_rst_code", result_code, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        lfsr_m = 8'hE1;
        conv_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_rv", result_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        conv_done = 1'b0;

        // Randomized conversions.
        for (int k = 0; k < 150; k++) begin
            s = 8'($urandom);
            n = int'($urandom_range(0, 20));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 1) == 0)
                    trials[j] = s + 8'($urandom_range(0, 2)) - 8'd1;
                else
                    trials[j] = 8'($urandom);
            end
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       fin = s;
                1:       fin = s + 8'd1;
                2:       fin = s - 8'd1;
                3:       fin = s + 8'd2;
                default: fin = 8'($urandom);
            endcase
            run_conv(s, n, fin, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_cmp_responder.md
# sar_cmp_responder

Synthesizable comparator/sample-and-hold responder for the 8-bit SAR conversion loop. It holds one sampled input value and answers each trial code from the SAR controller with a one-bit comparator decision (`1` means sample >= trial). When the controller signals completion, it checks the final code against the held sample. It sits on the comparator side of the SAR interface and serves as the digital stand-in for the analog front end in on-chip self-test and simulation.

## Interface
Parameters:
- `WIDTH`, default 8: sample and trial-code width.
- `LATENCY`, default 1: comparator pipeline depth in cycles. Legal range is 1..3.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `smp_data`, in, WIDTH: value to be converted.
- `smp_valid`, in, 1: sample offer.
- `smp_ready`, out, 1: hold register can accept a sample.
- `trial_code`, in, WIDTH: current SAR DAC trial code.
- `conv_done`, in, 1: SAR end-of-conversion strobe.
- `cmp_out`, out, 1: comparator decision.
- `busy`, out, 1: a conversion is in progress.
- `result_valid`, out, 1: one-cycle result pulse.
- `result_ok`, out, 1: final code matched the sample.
- `result_code`, out, WIDTH: final code captured at `conv_done`.
- `cmp_count`, out, 4: decisions issued in the current or last conversion.

## Operation
- The FSM has three states: IDLE, HOLD and REPORT. Reset enters IDLE.
- IDLE:
  - `smp_ready`=1.
  - When `smp_valid`=1, capture `smp_data` into `held` and go to HOLD.
  - Clear `cmp_count` on that transfer.
  - `conv_done` is ignored in IDLE.
- HOLD:
  - `busy`=1 and `smp_ready`=0. `smp_valid` is ignored.
  - Every cycle, the raw decision `(held >= trial_code)` is an unsigned compare. It is shifted into a LATENCY-deep pipeline.
  - `cmp_out` is the pipeline tail.
  - `cmp_count` increments every cycle and saturates at 15.
  - When `conv_done`=1:
    - capture `trial_code` into `result_code`;
    - set `result_ok` = (`trial_code` == `held`);
    - go to REPORT.
- REPORT:
  - `result_valid`=1 for exactly one cycle, then go to IDLE.
  - `result_code`, `result_ok` and `cmp_count` hold their values until the next sample transfer.
- Leaving HOLD flushes the decision pipeline to 0. `cmp_out`=0 in IDLE and REPORT.
- Boundary cases:
  - Trial code equal to the sample gives decision 1. This includes 0x00 vs 0x00 and 0xFF vs 0xFF.
  - `conv_done` in the same cycle as the sample transfer is ignored, because the FSM is still in IDLE.
  - `smp_valid` in REPORT is not accepted until IDLE.

## Timing
- Reset values:
  - `smp_ready`=1.
  - `busy`, `cmp_out`, `result_valid` and `result_ok` = 0.
  - `result_code`=0 and `cmp_count`=0.
  - `held`=0, and the decision pipeline is all 0.
- Assertion of `rst_n` takes effect immediately. A reset mid-HOLD aborts the conversion with no `result_valid`.
- Decision latency: the decision for the trial code sampled at edge N appears on `cmp_out` after edge N+LATENCY-1. With LATENCY=1, `cmp_out` is registered one cycle behind `trial_code`.
- Sample handshake: the transfer happens on the edge where `smp_valid` and `smp_ready` are both 1. `busy` rises the cycle after.
- `result_valid` rises the cycle after the edge on which `conv_done` is sampled in HOLD.
- Minimum sample-to-sample period is 3 cycles: transfer, at least one HOLD cycle with `conv_done`, then REPORT.

## Configuration
- Macro `SAR_CMP_NOISE_EN` adds comparator dither.
- When defined:
  - An 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 0xE1 at reset) advances every HOLD cycle.
  - When |`held` - `trial_code`| <= 1, the raw decision is XORed with LFSR bit 0.
  - `result_ok` = (|`result_code` - `held`| <= 1).
- When undefined:
  - There is no LFSR logic.
  - Decisions are exact and `result_ok` requires equality.

## Test plan
- Reset:
  - Drive `rst_n`=0 mid-HOLD, then release.
  - Require `smp_ready`=1 and `busy`/`cmp_out`/`result_valid`/`cmp_count` = 0, with no `result_valid` pulse.
- Nominal conversion, LATENCY=1:
  - Load 0x5A, then drive trial codes 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B.
  - Require `cmp_out` = 0,1,0,1,1,0,1,0, each one cycle later.
  - Then assert `conv_done` with 0x5A.
  - Require `result_valid` to pulse one cycle, `result_ok`=1, `result_code`=0x5A, `cmp_count`=8.
- Equality bounds:
  - Sample 0x00 with trial 0x00 gives `cmp_out`=1.
  - Sample 0xFF with trial 0xFF gives `cmp_out`=1.
  - Sample 0xFF with trial 0x00 gives 1. Sample 0x00 with trial 0x01 gives 0.
- Mismatch (macro undefined):
  - Sample 0x10, `conv_done` with 0x11.
  - Require `result_ok`=0 and `result_code`=0x11.
- Handshake exclusion:
  - Drive `smp_valid` during HOLD with 0x33, and `conv_done` in IDLE.
  - Require `held` unchanged, `smp_ready`=0 throughout HOLD, and no FSM change from IDLE.
- LATENCY=3 with `SAR_CMP_NOISE_EN`:
  - Require the decision to appear 3 cycles after its trial code, and the pipeline to be 0 after REPORT.
  - Sample 0x40, `conv_done` with 0x41: require `result_ok`=1.
  - Sample 0x40, `conv_done` with 0x42: require `result_ok`=0.
